// File: rtl/dpt_pkg.sv
// dpt_pkg: shared states, window codes and phase lengths
// for the double-pulse-test sequencer.
package dpt_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUALIFY = 3'd1,
    S_ARMED   = 3'd2,
    S_PULSE1  = 3'd3,
    S_GAP     = 3'd4,
    S_PULSE2  = 3'd5,
    S_COOL    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  localparam logic [15:0] VMIN_DEF = 16'h08B0;
  localparam logic [15:0] VMAX_DEF = 16'h0C0C;

  localparam int unsigned STABLE_N_DEF = 16;
  localparam int unsigned T1_DEF       = 400;
  localparam int unsigned TGAP_DEF     = 200;
  localparam int unsigned T2_DEF       = 200;
  localparam int unsigned TCOOL_DEF    = 40000;

  // Phases count down from n-1 to 0, so n cycles per phase.
  function automatic logic [15:0] ld_cnt(
    input int unsigned n
  );
    return 16'(n - 1);
  endfunction

endpackage

// File: rtl/dpt_if.sv
// dpt_if: control/status bundle between the ad/fault
// detect side and the DPT sequencer.
interface dpt_if;

  logic        start;
  logic        leg_sel;
  logic [15:0] volt;
  logic        volt_valid;
  logic [3:0]  igbt_err;
  logic        fault_clr;
  logic [3:0]  gate;
  logic        armed;
  logic        busy;
  logic        done;
  logic        fault;
  logic [2:0]  state_o;

  modport master (
    output start, leg_sel, volt, volt_valid,
    output igbt_err, fault_clr,
    input  gate, armed, busy, done, fault,
    input  state_o
  );

  modport slave (
    input  start, leg_sel, volt, volt_valid,
    input  igbt_err, fault_clr,
    output gate, armed, busy, done, fault,
    output state_o
  );

endinterface

// File: rtl/dpt_window_qual.sv
// dpt_window_qual: bus-voltage window compare and
// saturating count of consecutive in-window samples.
module dpt_window_qual #(
  parameter logic [15:0] VMIN     = 16'h08B0,
  parameter logic [15:0] VMAX     = 16'h0C0C,
  parameter int unsigned STABLE_N = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        volt_valid,
  input  logic [15:0] volt,
  output logic        in_win,
  output logic        qualified
);

  localparam logic [15:0] NSAT = 16'(STABLE_N);

  logic [15:0] stable_cnt;

  assign in_win = (volt > VMIN) && (volt <= VMAX);
  assign qualified = (stable_cnt == NSAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else if (clr) begin
      stable_cnt <= '0;
    end else if (volt_valid) begin
      if (!in_win)
        stable_cnt <= '0;
      else if (stable_cnt != NSAT)
        stable_cnt <= stable_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dpt_sequencer.sv
// dpt_sequencer: qualifies the DC bus, then fires one double
// pulse per start edge. DPT_FAULT_LATCH_EN latches FAULT.
module dpt_sequencer
  import dpt_pkg::*;
#(
  parameter logic [15:0] VMIN      = VMIN_DEF,
  parameter logic [15:0] VMAX      = VMAX_DEF,
  parameter int unsigned STABLE_N  = STABLE_N_DEF,
  parameter int unsigned T1_CYC    = T1_DEF,
  parameter int unsigned TGAP_CYC  = TGAP_DEF,
  parameter int unsigned T2_CYC    = T2_DEF,
  parameter int unsigned TCOOL_CYC = TCOOL_DEF
) (
  input logic  clk,
  input logic  sys_rst_n,
  dpt_if.slave bus
);

  state_t      state;
  state_t      nxt;
  logic [2:0]  sync;
  logic [15:0] phase;
  logic [15:0] phase_n;
  logic [3:0]  gate_q;
  logic        leg;
  logic        leg_n;
  logic        start_edge;
  logic        in_win;
  logic        qualified;
  logic        oow;
  logic        err_any;
  logic        q_clr;
  logic        done_ev;
  logic        armed_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;

  assign start_edge = sync[1] & ~sync[2];
  assign err_any    = |bus.igbt_err;
  assign oow        = bus.volt_valid & ~in_win;
  assign q_clr      = (state == S_COOL) &&
                      (nxt == S_QUALIFY);

  dpt_window_qual #(
    .VMIN     (VMIN),
    .VMAX     (VMAX),
    .STABLE_N (STABLE_N)
  ) u_qual (
    .clk        (clk),
    .rst_n      (sys_rst_n),
    .clr        (q_clr),
    .volt_valid (bus.volt_valid),
    .volt       (bus.volt),
    .in_win     (in_win),
    .qualified  (qualified)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    nxt = S_QUALIFY;
      S_QUALIFY: if (qualified) nxt = S_ARMED;
      S_ARMED: begin
        if (oow)             nxt = S_QUALIFY;
        else if (start_edge) nxt = S_PULSE1;
      end
      S_PULSE1: begin
        if (oow)               nxt = S_COOL;
        else if (phase == '0)  nxt = S_GAP;
      end
      S_GAP: begin
        if (oow)               nxt = S_COOL;
        else if (phase == '0)  nxt = S_PULSE2;
      end
      S_PULSE2: begin
        if (oow)               nxt = S_COOL;
        else if (phase == '0)  nxt = S_COOL;
      end
      S_COOL: if (phase == '0) nxt = S_QUALIFY;
      S_FAULT: begin
`ifdef DPT_FAULT_LATCH_EN
        if (bus.fault_clr && !err_any) nxt = S_COOL;
`else
        if (!err_any) nxt = S_COOL;
`endif
      end
    endcase
    // Fault overrides every other transition.
    if (err_any && state != S_IDLE) nxt = S_FAULT;
  end

  always_comb begin
    phase_n = (phase == '0) ? '0 : phase - 16'd1;
    if (nxt != state) begin
      case (nxt)
        S_PULSE1: phase_n = ld_cnt(T1_CYC);
        S_GAP:    phase_n = ld_cnt(TGAP_CYC);
        S_PULSE2: phase_n = ld_cnt(T2_CYC);
        S_COOL:   phase_n = ld_cnt(TCOOL_CYC);
        default:  phase_n = '0;
      endcase
    end
  end

  assign leg_n = (state == S_ARMED && nxt == S_PULSE1)
               ? bus.leg_sel : leg;
  assign done_ev = (state == S_PULSE2) &&
                   (nxt == S_COOL) && !oow;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      sync    <= '0;
      phase   <= '0;
      leg     <= 1'b0;
      gate_q  <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync    <= {sync[1:0], bus.start};
      state   <= nxt;
      phase   <= phase_n;
      leg     <= leg_n;
      if (nxt == S_PULSE1 || nxt == S_PULSE2)
        gate_q <= leg_n ? 4'b0100 : 4'b0001;
      else
        gate_q <= 4'b0000;
      armed_q <= (nxt == S_ARMED);
      busy_q  <= nxt inside {S_PULSE1, S_GAP, S_PULSE2};
      done_q  <= done_ev;
      fault_q <= (nxt == S_FAULT);
    end
  end

  assign bus.gate    = gate_q & {4{~err_any}};
  assign bus.armed   = armed_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.state_o = state;

`ifndef DPT_FAULT_LATCH_EN
  logic unused_clr;
  assign unused_clr = bus.fault_clr;
`endif

endmodule

// File: tb/tb_dpt_sequencer.sv
// tb_dpt_sequencer: vector tables, hand sequences and a
// random qualification stream against a behavioural model.
module tb_dpt_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpt_if dif();

  dpt_sequencer #(.TCOOL_CYC(500)) dut (
    .clk       (clk),
    .sys_rst_n (rst_n),
    .bus       (dif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic leg;
    int   a;
    logic extra;
    int   hi;
    int   dn;
  } seq_vec_t;

  typedef struct {
    logic [15:0] v;
    int          armed;
  } win_vec_t;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm();
    int k;
    k = 0;
    dif.volt = 16'h0A00;
    while (!dif.armed && k < 3000) begin
      dif.volt_valid = 1'b1;
      step();
      k++;
    end
    dif.volt_valid = 1'b0;
    if (!dif.armed) chk("arm_timeout", 0, 1);
  endtask

  // Gate-high cycles when an out-of-window sample lands
  // a cycles after PULSE1 entry (0: no abort).
  function automatic int model_hi(input int a);
    int h;
    if (a == 0) return 600;
    h = (a < 400) ? a : 400;
    if (a > 600) h += (a - 600 < 200) ? a - 600 : 200;
    return h;
  endfunction

  function automatic int model_done(input int a);
    return (a == 0 || a > 800) ? 1 : 0;
  endfunction

  task automatic run_seq(
    input  logic leg, input int a, input logic extra,
    output int hi, output int other, output int hs,
    output int dn, output int early, output int first
  );
    hi = 0; other = 0; hs = 0; dn = 0; first = -1;
    dif.leg_sel = leg;
    dif.start = 1'b1;
    steps(2);
    early = int'(dif.gate != 4'b0000);
    step();
    for (int j = 0; j < 1000; j++) begin
      if (dif.gate[leg ? 2 : 0]) begin
        hi++;
        if (first < 0) first = j;
      end
      if (dif.gate[leg ? 0 : 2]) other++;
      if (dif.gate[1] | dif.gate[3]) hs++;
      if (dif.done) dn++;
      dif.start = extra && j >= 100 && j < 110;
      dif.leg_sel = (extra && j >= 50) ? ~leg : leg;
      dif.volt_valid = (a != 0 && j == a - 1);
      dif.volt = dif.volt_valid ? 16'h0C0D : 16'h0A00;
      step();
    end
    dif.volt_valid = 1'b0;
    dif.volt = 16'h0A00;
    dif.leg_sel = leg;
  endtask

  seq_vec_t sv[9];
  win_vec_t wv[7];

  initial begin
    int hi, other, hs, dn, early, first, act, run;
    int armed_m, nxt_m, inw, a, sel;
    logic leg, vld;
    logic [15:0] v;

    sv[0] = '{1'b0, 0,   1'b0, 600, 1};
    sv[1] = '{1'b1, 0,   1'b0, 600, 1};
    sv[2] = '{1'b0, 0,   1'b1, 600, 1};
    sv[3] = '{1'b0, 500, 1'b0, 400, 0};
    sv[4] = '{1'b1, 150, 1'b0, 150, 0};
    sv[5] = '{1'b0, 700, 1'b0, 500, 0};
    sv[6] = '{1'b1, 800, 1'b0, 600, 0};
    sv[7] = '{1'b0, 1,   1'b0, 1,   0};
    sv[8] = '{1'b1, 401, 1'b0, 400, 0};

    wv[0] = '{16'h08B0, 0};
    wv[1] = '{16'h08B1, 1};
    wv[2] = '{16'h0C0C, 1};
    wv[3] = '{16'h0C0D, 0};
    wv[4] = '{16'h0000, 0};
    wv[5] = '{16'hFFFF, 0};
    wv[6] = '{16'h0A00, 1};

    dif.start = 0; dif.leg_sel = 0; dif.volt = 0;
    dif.volt_valid = 0; dif.igbt_err = 0;
    dif.fault_clr = 0;
    rst_n = 1'b0;
    steps(3);
    chk("rst_gate", int'(dif.gate), 0);
    chk("rst_armed", int'(dif.armed), 0);
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_fault", int'(dif.fault), 0);
    chk("rst_state", int'(dif.state_o), 0);
    rst_n = 1'b1;
    step();
    chk("idle_to_qualify", int'(dif.state_o), 1);

    // start while still qualifying is dropped
    dif.start = 1'b1;
    steps(3);
    dif.start = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (dif.gate != 0 || dif.busy) act++;
      step();
    end
    chk("start_in_qualify", act, 0);
    chk("qualify_state", int'(dif.state_o), 1);

    // 16 in-window samples, one every 16 clk
    dif.volt = 16'h0A00;
    for (int i = 0; i < 16; i++) begin
      dif.volt_valid = 1'b1;
      step();
      dif.volt_valid = 1'b0;
      if (i < 15) steps(15);
      if (i == 14) chk("armed_after_15", int'(dif.armed), 0);
    end
    step();
    chk("armed_after_16", int'(dif.armed), 1);
    chk("armed_state", int'(dif.state_o), 2);

    for (int i = 0; i < 9; i++) begin
      arm();
      run_seq(sv[i].leg, sv[i].a, sv[i].extra,
              hi, other, hs, dn, early, first);
      chk($sformatf("seq%0d_hi", i), hi, sv[i].hi);
      chk($sformatf("seq%0d_other", i), other, 0);
      chk($sformatf("seq%0d_hside", i), hs, 0);
      chk($sformatf("seq%0d_done", i), dn, sv[i].dn);
      chk($sformatf("seq%0d_early", i), early, 0);
      chk($sformatf("seq%0d_first", i), first, 0);
    end

    for (int i = 0; i < 7; i++) begin
      arm();
      dif.volt = wv[i].v;
      dif.volt_valid = 1'b1;
      step();
      dif.volt_valid = 1'b0;
      dif.volt = 16'h0A00;
      step();
      chk($sformatf("win%0d_armed", i),
          int'(dif.armed), wv[i].armed);
      chk($sformatf("win%0d_state", i),
          int'(dif.state_o), wv[i].armed ? 2 : 1);
    end

    for (int r = 0; r < 5; r++) begin
      a = ($urandom_range(0, 3) == 0)
        ? 0 : int'($urandom_range(1, 900));
      leg = 1'($urandom_range(0, 1));
      arm();
      run_seq(leg, a, 1'b0, hi, other, hs, dn, early, first);
      chk($sformatf("rseq%0d_hi", r), hi, model_hi(a));
      chk($sformatf("rseq%0d_done", r), dn, model_done(a));
      chk($sformatf("rseq%0d_other", r), other, 0);
    end

    // igbt fault mid-PULSE1
    arm();
    dif.leg_sel = 1'b0;
    dif.start = 1'b1;
    steps(3);
    dif.start = 1'b0;
    steps(100);
    chk("prefault_gate", int'(dif.gate), 1);
    dif.igbt_err = 4'b0010;
    #1;
    chk("fault_gate_comb", int'(dif.gate), 0);
    step();
    chk("fault_flag", int'(dif.fault), 1);
    chk("fault_state", int'(dif.state_o), 7);
    chk("fault_busy", int'(dif.busy), 0);
    steps(5);
    chk("fault_hold", int'(dif.fault), 1);
`ifdef DPT_FAULT_LATCH_EN
    dif.fault_clr = 1'b1;
    step();
    dif.fault_clr = 1'b0;
    chk("clr_with_err", int'(dif.state_o), 7);
    dif.igbt_err = 4'b0000;
    steps(3);
    chk("latched_hold", int'(dif.state_o), 7);
    dif.fault_clr = 1'b1;
    step();
    dif.fault_clr = 1'b0;
`else
    dif.igbt_err = 4'b0000;
    step();
`endif
    chk("fault_exit_state", int'(dif.state_o), 6);
    chk("fault_exit_flag", int'(dif.fault), 0);

    // start during cooldown is dropped
    dif.start = 1'b1;
    steps(3);
    dif.start = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (dif.gate != 0 || dif.busy) act++;
      step();
    end
    chk("start_in_cool", act, 0);
    chk("cool_state", int'(dif.state_o), 6);

    // reset mid-PULSE2
    arm();
    dif.start = 1'b1;
    steps(3);
    dif.start = 1'b0;
    steps(650);
    chk("p2_gate", int'(dif.gate), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_gate", int'(dif.gate), 0);
    chk("arst_busy", int'(dif.busy), 0);
    chk("arst_armed", int'(dif.armed), 0);
    chk("arst_done", int'(dif.done), 0);
    chk("arst_fault", int'(dif.fault), 0);
    chk("arst_state", int'(dif.state_o), 0);
    steps(2);
    rst_n = 1'b1;
    #1;
    chk("rel_idle", int'(dif.state_o), 0);
    step();
    chk("rel_qualify", int'(dif.state_o), 1);

    // random sample stream vs run-length model
    run = 0;
    armed_m = 0;
    for (int i = 0; i < 400; i++) begin
      chk($sformatf("rand%0d_armed", i),
          int'(dif.armed), armed_m);
      vld = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: v = 16'h08B0;
        1: v = 16'h08B1;
        2: v = 16'h0C0C;
        3: v = 16'h0C0D;
        4: v = 16'($urandom);
        default: v = 16'h0900 + 16'($urandom_range(0, 16'h2FF));
      endcase
      inw = (v > 16'h08B0 && v <= 16'h0C0C) ? 1 : 0;
      if (armed_m != 0)
        nxt_m = (vld && inw == 0) ? 0 : 1;
      else
        nxt_m = (run >= 16) ? 1 : 0;
      if (vld) run = (inw != 0) ? run + 1 : 0;
      armed_m = nxt_m;
      dif.volt = v;
      dif.volt_valid = vld;
      step();
    end
    dif.volt_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
